// File: rtl/uart_mmio_bridge_pkg.sv
// Shared constants, read-select encoding and status-word packing for the UART MMIO bridge.
package uart_mmio_bridge_pkg;

  localparam logic [31:0] UART_BASE_DEFAULT = 32'h1fe0_01e0;
  localparam logic [31:0] UART_DATA_OFS     = 32'd0;
  localparam logic [31:0] UART_STAT_OFS     = 32'd4;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;

  typedef enum logic [1:0] {
    RSEL_RAM  = 2'd0,
    RSEL_DATA = 2'd1,
    RSEL_STAT = 2'd2
  } rsel_e;

  function automatic logic [31:0] pack_stat(input logic [7:0] count, input logic ovf,
                                            input logic empty, input logic full);
    logic [31:0] w;
    w                 = '0;
    w[15:8]           = count;
    w[STAT_OVF_BIT]   = ovf;
    w[STAT_EMPTY_BIT] = empty;
    w[STAT_FULL_BIT]  = full;
    return w;
  endfunction

endpackage

// File: rtl/uart_mmio_bridge_if.sv
// Flat RAM-style port: the CPU side drives it as master, the bridge forwards it to RAM as master.
interface uart_mmio_bridge_if;
  logic        en;
  logic [31:0] raddr;
  logic [31:0] rdata;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        wen;

  modport master (output en, raddr, waddr, wdata, wen, input  rdata);
  modport slave  (input  en, raddr, waddr, wdata, wen, output rdata);
endinterface

// File: rtl/uart_mmio_bridge_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a push into a full FIFO is accepted when a pop frees the slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_mmio_bridge.sv
// Passes CPU RAM traffic through and decodes a two-word UART window: TX data queued and drained,
// RX data sampled on read, status readable with a sticky clear-on-read overflow flag.
module uart_mmio_bridge
  import uart_mmio_bridge_pkg::*;
#(
  parameter logic [31:0] UART_BASE  = UART_BASE_DEFAULT,
  parameter int          FIFO_DEPTH = 16,
  parameter int          DRAIN_DIV  = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  uart_mmio_bridge_if.slave         cpu,
  uart_mmio_bridge_if.master        ram,
  output logic                      uart_out_valid_o,
  output logic [7:0]                uart_out_ch_o,
  output logic                      uart_in_valid_o,
  input  logic [7:0]                uart_in_ch_i
);
  localparam int               CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int               DRAIN_W    = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
  localparam logic [31:0]      DATA_ADDR  = UART_BASE + UART_DATA_OFS;
  localparam logic [31:0]      STAT_ADDR  = UART_BASE + UART_STAT_OFS;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_DIV - 1);

  logic             data_wr, stat_wr, mmio_wr, data_rd, stat_rd;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [7:0]       fifo_head;
  logic [CNT_W-1:0] fifo_count;

  rsel_e              rsel_q, rsel_d;
  logic [31:0]        mmio_rdata_q, mmio_rdata_d;
  logic               ovf_q, ovf_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               out_valid_q;
  logic [7:0]         out_ch_q, out_ch_d;

  // Decode ignores the byte offset within the word.
  assign data_wr = cpu.en & cpu.wen & (cpu.waddr[31:2] == DATA_ADDR[31:2]);
  assign stat_wr = cpu.en & cpu.wen & (cpu.waddr[31:2] == STAT_ADDR[31:2]);
  assign mmio_wr = data_wr | stat_wr;
  assign data_rd = cpu.en & (cpu.raddr[31:2] == DATA_ADDR[31:2]);
  assign stat_rd = cpu.en & (cpu.raddr[31:2] == STAT_ADDR[31:2]);

  assign ram.en    = cpu.en;
  assign ram.wen   = cpu.wen & ~mmio_wr;
  assign ram.raddr = cpu.raddr;
  assign ram.waddr = cpu.waddr;
  assign ram.wdata = cpu.wdata;
  assign cpu.rdata = (rsel_q == RSEL_RAM) ? ram.rdata : mmio_rdata_q;

  assign uart_in_valid_o  = data_rd;
  assign uart_out_valid_o = out_valid_q;
  assign uart_out_ch_o    = out_ch_q;

  assign fifo_pop  = (drain_q == '0) & ~fifo_empty;
  assign fifo_push = data_wr & (~fifo_full | fifo_pop);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (cpu.wdata[7:0]),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    rsel_d       = rsel_q;
    mmio_rdata_d = mmio_rdata_q;
    if (cpu.en) begin
      if (data_rd) begin
        rsel_d       = RSEL_DATA;
        mmio_rdata_d = {24'b0, uart_in_ch_i};
      end else if (stat_rd) begin
        rsel_d       = RSEL_STAT;
        mmio_rdata_d = pack_stat(8'(fifo_count), ovf_q, fifo_empty, fifo_full);
      end else begin
        rsel_d       = RSEL_RAM;
        mmio_rdata_d = '0;
      end
    end

    // A dropped write in the same cycle as a status read keeps the flag set.
    ovf_d = ovf_q;
    if (stat_rd)                            ovf_d = 1'b0;
    if (data_wr && fifo_full && !fifo_pop)  ovf_d = 1'b1;

    drain_d  = (drain_q == DRAIN_LAST) ? '0 : drain_q + DRAIN_W'(1);
    out_ch_d = fifo_pop ? fifo_head : out_ch_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsel_q       <= RSEL_RAM;
      mmio_rdata_q <= '0;
      ovf_q        <= 1'b0;
      drain_q      <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
    end else begin
      rsel_q       <= rsel_d;
      mmio_rdata_q <= mmio_rdata_d;
      ovf_q        <= ovf_d;
      drain_q      <= drain_d;
      out_valid_q  <= fifo_pop;
      out_ch_q     <= out_ch_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Scoreboard bench: three bridge instances (default, slow drain, tiny FIFO) on a shared CPU stimulus bus.
module tb_uart_mmio_bridge;
  localparam logic [31:0] DATA_A = 32'h1fe0_01e0;
  localparam logic [31:0] STAT_A = 32'h1fe0_01e4;
  localparam logic [31:0] RAM_A  = 32'h1c00_0010;
  localparam int          DIV_B  = 64;
  localparam int          DIV_C  = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic        cpu_en    = 1'b0;
  logic        cpu_wen   = 1'b0;
  logic [31:0] cpu_raddr = '0;
  logic [31:0] cpu_waddr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [7:0]  uart_in_ch = 8'hff;
  int          sel = 0;
  logic        rd_req = 1'b0;
  logic        rd_due = 1'b0;

  logic [2:0]  out_valid, in_valid, ram_wen, ram_en;
  logic [7:0]  out_ch [3];
  logic [31:0] rdata [3];
  logic [31:0] ram_rdq = '0;
  logic [31:0] mem [256];

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt;

  logic [7:0]  txq0 [$], txq1 [$], txq2 [$];
  logic [31:0] rd_exp [$];
  int          rd_inst [$];

  uart_mmio_bridge_if cpu_a(), cpu_b(), cpu_c();
  uart_mmio_bridge_if ram_a(), ram_b(), ram_c();

  assign cpu_a.en = cpu_en && (sel == 0);
  assign cpu_b.en = cpu_en && (sel == 1);
  assign cpu_c.en = cpu_en && (sel == 2);
  assign cpu_a.wen = cpu_wen;   assign cpu_b.wen = cpu_wen;   assign cpu_c.wen = cpu_wen;
  assign cpu_a.raddr = cpu_raddr; assign cpu_b.raddr = cpu_raddr; assign cpu_c.raddr = cpu_raddr;
  assign cpu_a.waddr = cpu_waddr; assign cpu_b.waddr = cpu_waddr; assign cpu_c.waddr = cpu_waddr;
  assign cpu_a.wdata = cpu_wdata; assign cpu_b.wdata = cpu_wdata; assign cpu_c.wdata = cpu_wdata;
  assign ram_a.rdata = ram_rdq;
  assign ram_b.rdata = '0;
  assign ram_c.rdata = '0;

  assign ram_wen = {ram_c.wen, ram_b.wen, ram_a.wen};
  assign ram_en  = {ram_c.en, ram_b.en, ram_a.en};
  assign rdata[0] = cpu_a.rdata;
  assign rdata[1] = cpu_b.rdata;
  assign rdata[2] = cpu_c.rdata;

  uart_mmio_bridge u_dut_a (
    .clock(clock), .reset_n(reset_n), .cpu(cpu_a), .ram(ram_a),
    .uart_out_valid_o(out_valid[0]), .uart_out_ch_o(out_ch[0]),
    .uart_in_valid_o(in_valid[0]), .uart_in_ch_i(uart_in_ch));

  uart_mmio_bridge #(.DRAIN_DIV(DIV_B)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .cpu(cpu_b), .ram(ram_b),
    .uart_out_valid_o(out_valid[1]), .uart_out_ch_o(out_ch[1]),
    .uart_in_valid_o(in_valid[1]), .uart_in_ch_i(uart_in_ch));

  uart_mmio_bridge #(.FIFO_DEPTH(4), .DRAIN_DIV(DIV_C)) u_dut_c (
    .clock(clock), .reset_n(reset_n), .cpu(cpu_c), .ram(ram_c),
    .uart_out_valid_o(out_valid[2]), .uart_out_ch_o(out_ch[2]),
    .uart_in_valid_o(in_valid[2]), .uart_in_ch_i(uart_in_ch));

  // Behavioural RAM behind instance A, one-cycle read latency.
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge clock) begin
    if (ram_a.en) begin
      if (ram_a.wen) mem[ram_a.waddr[9:2]] <= ram_a.wdata;
      ram_rdq <= mem[ram_a.raddr[9:2]];
    end
  end

  // Index of the next rising edge since reset release; equals the drain counter phase mod DRAIN_DIV.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic push_tx(input int inst, input logic [7:0] ch);
    case (inst)
      0:       txq0.push_back(ch);
      1:       txq1.push_back(ch);
      default: txq2.push_back(ch);
    endcase
  endtask

  task automatic tx_seen(input int inst, input logic [7:0] ch);
    int n;
    logic [7:0] exp;
    case (inst)
      0:       n = txq0.size();
      1:       n = txq1.size();
      default: n = txq2.size();
    endcase
    check($sformatf("tx%0d_expected", inst), {31'b0, n != 0}, 32'd1);
    if (n != 0) begin
      case (inst)
        0:       exp = txq0.pop_front();
        1:       exp = txq1.pop_front();
        default: exp = txq2.pop_front();
      endcase
      check($sformatf("tx%0d_ch", inst), {24'b0, ch}, {24'b0, exp});
    end
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) if (out_valid[i]) tx_seen(i, out_ch[i]);
  end

  always @(posedge clock) rd_due <= rd_req & cpu_en;

  always @(negedge clock) begin
    if (rd_due) begin
      check("rd_expected", {31'b0, rd_exp.size() != 0}, 32'd1);
      if (rd_exp.size() != 0) begin
        int inst;
        inst = rd_inst.pop_front();
        check($sformatf("rd%0d_data", inst), rdata[inst], rd_exp.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    cpu_en  = 1'b0;
    cpu_wen = 1'b0;
    rd_req  = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic cpu_write(input int inst, input logic [31:0] addr, input logic [31:0] data,
                           input logic exp_ram_wen, input logic exp_tx);
    sel = inst; cpu_en = 1'b1; cpu_wen = 1'b1; rd_req = 1'b0;
    cpu_waddr = addr; cpu_wdata = data; cpu_raddr = 32'h0;
    if (exp_tx) push_tx(inst, data[7:0]);
    #1;
    check($sformatf("ram_wen%0d", inst), {31'b0, ram_wen[inst]}, {31'b0, exp_ram_wen});
    @(negedge clock);
  endtask

  task automatic cpu_read(input int inst, input logic [31:0] addr, input logic [31:0] exp,
                          input logic exp_in_valid);
    sel = inst; cpu_en = 1'b1; cpu_wen = 1'b0; rd_req = 1'b1;
    cpu_raddr = addr;
    rd_exp.push_back(exp);
    rd_inst.push_back(inst);
    #1;
    check($sformatf("in_valid%0d", inst), {31'b0, in_valid[inst]}, {31'b0, exp_in_valid});
    @(negedge clock);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int left;
    repeat (2) @(negedge clock);
    #1;
    check("rst_out_valid", {31'b0, out_valid[0]}, 32'd0);
    check("rst_out_ch",    {24'b0, out_ch[0]},    32'd0);
    check("rst_in_valid",  {31'b0, in_valid[0]},  32'd0);
    check("rst_ram_en",    {31'b0, ram_en[0]},    32'd0);
    check("rst_rdata",     rdata[0],              32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // RAM pass-through
    cpu_write(0, RAM_A, 32'hdead_beef, 1'b1, 1'b0);
    cpu_read(0, RAM_A, 32'hdead_beef, 1'b0);
    idle(2);

    // TX basic: two back-to-back DATA writes
    cpu_write(0, DATA_A, 32'h0000_0048, 1'b0, 1'b1);
    cpu_write(0, DATA_A, 32'h0000_0069, 1'b0, 1'b1);
    cpu_write(0, STAT_A, 32'h0000_00aa, 1'b0, 1'b0);
    idle(3);

    // RX read
    uart_in_ch = 8'h41;
    cpu_read(0, DATA_A, 32'h0000_0041, 1'b1);
    uart_in_ch = 8'hff;
    idle(2);

    // Overflow: 17 writes right after a drain slot, none popped meanwhile
    while ((edge_cnt % DIV_B) != 1) @(negedge clock);
    for (int i = 0; i < 17; i++) cpu_write(1, DATA_A, 32'h30 + i, 1'b0, i < 16);
    cpu_read(1, STAT_A, 32'h0000_1005, 1'b0);
    cpu_read(1, STAT_A, 32'h0000_1001, 1'b0);
    idle(1);

    // Full FIFO with a pop in the same cycle accepts the push
    while ((edge_cnt % DIV_C) != 0) @(negedge clock);
    for (int i = 0; i < 4; i++) cpu_write(2, DATA_A, 32'ha0 + i, 1'b0, 1'b1);
    cpu_write(2, DATA_A, 32'h0000_0055, 1'b0, 1'b1);
    cpu_read(2, STAT_A, 32'h0000_0401, 1'b0);
    idle(1);

    left = txq0.size() + txq1.size() + txq2.size();
    for (int k = 0; k < 3000 && left != 0; k++) begin
      @(negedge clock);
      left = txq0.size() + txq1.size() + txq2.size();
    end
    check("tx_drained", left, 32'd0);

    // Reset in the middle of draining three characters
    cpu_write(0, DATA_A, 32'h31, 1'b0, 1'b1);
    cpu_write(0, DATA_A, 32'h32, 1'b0, 1'b1);
    cpu_write(0, DATA_A, 32'h33, 1'b0, 1'b0);
    cpu_en = 1'b0; cpu_wen = 1'b0;
    #1;
    check("pre_rst_valid", {31'b0, out_valid[0]}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, out_valid[0]}, 32'd0);
    check("mid_rst_ch",    {24'b0, out_ch[0]},    32'd0);
    txq0.delete();
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    cpu_read(0, STAT_A, 32'h0000_0002, 1'b0);
    idle(3);

    check("rd_queue_empty", rd_exp.size(), 32'd0);
    check("tx_queue_empty", txq0.size() + txq1.size() + txq2.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
